alu_ctl_mc: RTL
===============

ALU_CTL_MC -- requirements
Module: alu_ctl_mc

Interface
REQ-001 SHALL expose parameter MUL_CYCLES, default 34: number of cycles SignaltoMULTU is held for one MULTU (legal range 1..127).
REQ-002 SHALL expose parameter DIV_CYCLES, default 34: number of cycles SignaltoDIVU is held for one DIVU (legal range 1..127).
REQ-003 SHALL expose parameter DIV_EN, default 1: 0 makes DIVU decode as illegal.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 op_valid  in  1  instruction in EX is valid this cycle.
REQ-007 ALUOp  in  2  main-decoder class: 00 add, 01 sub, 10 R-type.
REQ-008 Funct  in  6  R-type function field.
REQ-009 SignaltoALU  out  3  ALU operation code.
REQ-010 SignaltoSHT  out  3  shifter operation code, always equal to SignaltoALU.
REQ-011 SignaltoMUX  out  2  result select: 00 ALU, 01 HI, 10 LO, 11 shifter.
REQ-012 SignaltoMULTU  out  1  multiplier run enable.
REQ-013 SignaltoDIVU  out  1  divider run enable.
REQ-014 stall  out  1  freezes IF/ID/EX while a multi-cycle op runs.
REQ-015 hilo_we  out  1  one-cycle HI/LO write strobe at end of op.
REQ-016 illegal  out  1  unrecognised Funct with ALUOp=10 and op_valid.

Function
REQ-017 Decode SHALL be combinational from ALUOp/Funct: ALUOp 00 -> 010, 01 -> 110; ALUOp 10: ADD 100000 -> 010, SUB 100010 -> 110, AND 100100 -> 000, OR 100101 -> 001, SLT 101010 -> 111, SLL 000000 -> 011, MFHI 010000 -> 100, MFLO 010010 -> 101.
REQ-018 SignaltoMUX SHALL be 11 for SLL, 01 for MFHI, 10 for MFLO, else 00.
REQ-019 Unknown Funct or ALUOp=11 SHALL drive SignaltoALU=010 (never X), SignaltoMUX=00, and illegal=op_valid.
REQ-020 FSM states IDLE, MUL, DIV, DONE; a cycle counter of 7 bits.
REQ-021 IDLE -> MUL on op_valid & ALUOp=10 & Funct=011001; counter loads MUL_CYCLES-1.
REQ-022 IDLE -> DIV on op_valid & ALUOp=10 & Funct=011011 & DIV_EN=1; counter loads DIV_CYCLES-1.
REQ-023 In MUL/DIV counter SHALL decrement each cycle; at counter=0 state -> DONE.
REQ-024 SignaltoMULTU=1 exactly while state=MUL (MUL_CYCLES cycles); SignaltoDIVU likewise in DIV.
REQ-025 DONE SHALL last one cycle with hilo_we=1, then -> IDLE unconditionally.
REQ-026 stall SHALL be 1 in MUL and DIV, 0 in IDLE and DONE; a MULTU/DIVU issue cycle itself does not stall.
REQ-027 MFHI/MFLO/MULTU/DIVU presented while stall=1 SHALL be ignored by the FSM (held instruction re-presents after stall drops).
REQ-028 MULTU/DIVU accepted in the DONE cycle SHALL transition directly DONE -> MUL/DIV (back-to-back, no idle gap).
REQ-029 op_valid=0 SHALL never start an op; decode outputs still follow ALUOp/Funct.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, counter=0, SignaltoMULTU=0, SignaltoDIVU=0, stall=0, hilo_we=0, aborting any op in progress with no hilo_we.
REQ-031 rst SHALL take priority over every start condition in the same cycle.

Structure
REQ-032 Funct codes, ALU operation codes, MUX select codes and FSM state encodings SHALL live in shared package alu_defs_pkg.
REQ-033 Combinational decode SHALL be sub-module alu_dec; alu_ctl_mc holds FSM and counter.

Verification
REQ-034 ALUOp=10, each listed Funct, op_valid=1 -> SignaltoALU/SignaltoMUX per REQ-017/018, stall=0, illegal=0.
REQ-035 MULTU with MUL_CYCLES=34 -> SignaltoMULTU high cycles 1..34 after issue, hilo_we high cycle 35 only, stall high cycles 1..34.
REQ-036 MFLO held during MULTU busy -> no FSM change; after stall drops SignaltoMUX=10, SignaltoALU=101.
REQ-037 rst asserted at busy cycle 10 of DIVU -> next cycle IDLE, all control outputs 0, no hilo_we.
REQ-038 MULTU then DIVU issued in DONE cycle -> SignaltoDIVU rises next cycle, no IDLE cycle between.
REQ-039 Funct=111111 with op_valid=1, and DIVU with DIV_EN=0 -> illegal=1, SignaltoALU=010, FSM stays IDLE.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared encodings for the EX-stage ALU control: Funct codes, ALU/MUX codes and FSM states.
package alu_defs_pkg;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpRtype = 2'b10;

   localparam logic [5:0] FunctAdd   = 6'b100000;
   localparam logic [5:0] FunctSub   = 6'b100010;
   localparam logic [5:0] FunctAnd   = 6'b100100;
   localparam logic [5:0] FunctOr    = 6'b100101;
   localparam logic [5:0] FunctSlt   = 6'b101010;
   localparam logic [5:0] FunctSll   = 6'b000000;
   localparam logic [5:0] FunctMfhi  = 6'b010000;
   localparam logic [5:0] FunctMflo  = 6'b010010;
   localparam logic [5:0] FunctMultu = 6'b011001;
   localparam logic [5:0] FunctDivu  = 6'b011011;

   localparam logic [2:0] AluAnd  = 3'b000;
   localparam logic [2:0] AluOr   = 3'b001;
   localparam logic [2:0] AluAdd  = 3'b010;
   localparam logic [2:0] AluSll  = 3'b011;
   localparam logic [2:0] AluMfhi = 3'b100;
   localparam logic [2:0] AluMflo = 3'b101;
   localparam logic [2:0] AluSub  = 3'b110;
   localparam logic [2:0] AluSlt  = 3'b111;

   localparam logic [1:0] MuxAlu = 2'b00;
   localparam logic [1:0] MuxHi  = 2'b01;
   localparam logic [1:0] MuxLo  = 2'b10;
   localparam logic [1:0] MuxSht = 2'b11;

   localparam int unsigned CntW = 7;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU/shifter/result-mux decode from ALUOp and Funct.
module alu_dec
   import alu_defs_pkg::*;
#(
   parameter int unsigned DIV_EN = 1
) (
   input  logic       op_valid_i,
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_ctl_o,
   output logic [1:0] mux_sel_o,
   output logic       is_mul_o,
   output logic       is_div_o,
   output logic       illegal_o
);

   logic unknown;

   always_comb begin
      alu_ctl_o = AluAdd;
      mux_sel_o = MuxAlu;
      is_mul_o  = 1'b0;
      is_div_o  = 1'b0;
      unknown   = 1'b0;
      case (alu_op_i)
         AluOpAdd: alu_ctl_o = AluAdd;
         AluOpSub: alu_ctl_o = AluSub;
         AluOpRtype: begin
            case (funct_i)
               FunctAdd:   alu_ctl_o = AluAdd;
               FunctSub:   alu_ctl_o = AluSub;
               FunctAnd:   alu_ctl_o = AluAnd;
               FunctOr:    alu_ctl_o = AluOr;
               FunctSlt:   alu_ctl_o = AluSlt;
               FunctSll:   begin alu_ctl_o = AluSll;  mux_sel_o = MuxSht; end
               FunctMfhi:  begin alu_ctl_o = AluMfhi; mux_sel_o = MuxHi;  end
               FunctMflo:  begin alu_ctl_o = AluMflo; mux_sel_o = MuxLo;  end
               FunctMultu: is_mul_o = 1'b1;
               // With the divider removed DIVU falls through as an unknown opcode
               FunctDivu: begin
                  if (DIV_EN != 0) is_div_o = 1'b1;
                  else             unknown  = 1'b1;
               end
               default:    unknown = 1'b1;
            endcase
         end
         default: unknown = 1'b1;
      endcase
      illegal_o = op_valid_i & unknown;
   end

endmodule

// File: rtl/alu_ctl_mc.sv
// EX-stage ALU control with multi-cycle MULTU/DIVU sequencing, pipeline stall and HI/LO strobe.
module alu_ctl_mc
   import alu_defs_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 34,
   parameter int unsigned DIV_CYCLES = 34,
   parameter int unsigned DIV_EN     = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] SignaltoALU,
   output logic [2:0] SignaltoSHT,
   output logic [1:0] SignaltoMUX,
   output logic       SignaltoMULTU,
   output logic       SignaltoDIVU,
   output logic       stall,
   output logic       hilo_we,
   output logic       illegal
);

   localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
   localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            is_mul, is_div;
   logic [2:0]      alu_ctl;

   alu_dec #(
      .DIV_EN(DIV_EN)
   ) u_dec (
      .op_valid_i(op_valid),
      .alu_op_i  (ALUOp),
      .funct_i   (Funct),
      .alu_ctl_o (alu_ctl),
      .mux_sel_o (SignaltoMUX),
      .is_mul_o  (is_mul),
      .is_div_o  (is_div),
      .illegal_o (illegal)
   );

   assign SignaltoALU = alu_ctl;
   assign SignaltoSHT = alu_ctl;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         // DONE accepts a new op like IDLE so back-to-back ops leave no gap
         StIdle, StDone: begin
            if (op_valid && is_mul) begin
               state_d = StMul;
               cnt_d   = MulLoad;
            end else if (op_valid && is_div) begin
               state_d = StDiv;
               cnt_d   = DivLoad;
            end else begin
               state_d = StIdle;
            end
         end
         StMul, StDiv: begin
            if (cnt_q == '0) state_d = StDone;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      SignaltoMULTU = (state_q == StMul);
      SignaltoDIVU  = (state_q == StDiv);
      stall         = (state_q == StMul) || (state_q == StDiv);
      hilo_we       = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
